// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Packs mnemonic-level instruction requests into 16-bit words of the form
// {op, rd, imm} and writes them to consecutive instruction-memory addresses.
// Load bursts are started by start/base_addr/len. Each burst ends with one
// DRAIN cycle and then a one-cycle done pulse.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready.
// in_ready comes only from registered state (FSM state and the write
// pointer), so it never depends combinationally on in_valid. While in_valid
// is high and in_ready is low, the requester must hold kind/alu_op/rd/imm
// stable.
module instr_encoder_loader #(
  parameter int N      = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [2:0]        alu_op,
  input  logic [3:0]        rd,
  input  logic [7:0]        imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [N-1:0]      imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // The pointer is one bit wider than the address so it can reach DEPTH,
  // which is the overflow marker.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   ptr;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len_q;
  logic              ovf;
  logic              accept;
  logic              illegal;
  logic [3:0]        op;
  logic [N-1:0]      word;
  logic [ADDR_W:0]   cnt_next;

  assign ovf       = (ptr == DEPTH_L);
  assign in_ready  = (state == S_LOAD) && !ovf;
  assign accept    = in_valid && in_ready;
  assign busy      = (state == S_LOAD) || (state == S_DRAIN);
  assign fsm_state = state;
  assign cnt_next  = cnt + 1'b1;
  assign word      = N'({op, rd, imm});

  // Map kind/alu_op to the opcode nibble and flag requests that have no encoding.
  always_comb begin
    op      = 4'b0000;
    illegal = 1'b0;
    case (kind)
      3'd0: op = 4'b0000;
      3'd1: begin
        op      = {1'b0, alu_op};
        illegal = (alu_op == 3'b000);
      end
      3'd2: op = 4'b1000;
      3'd3: op = 4'b1001;
      3'd4: op = 4'b1010;
      3'd5: op = 4'b1100;
      3'd6: op = 4'b1101;
      default: illegal = 1'b1;
    endcase
  end

  // Burst FSM: holds the write pointer, the accept counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      len_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr   <= {1'b0, base_addr};
            len_q <= len;
            cnt   <= '0;
            err   <= 1'b0;
            if (len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (ovf) begin
            // The pointer ran off the end of memory, so the burst is truncated.
            err   <= 1'b1;
            state <= S_DRAIN;
          end else if (accept) begin
            cnt <= cnt_next;
            if (illegal) begin
              err <= 1'b1;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr[ADDR_W-1:0];
              imem_wdata <= word;
              ptr        <= ptr + 1'b1;
            end
            if (cnt_next == len_q) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader. It drives directed load bursts.
// Expected writes ({cycle, addr, word}) go into a queue, and a negedge
// monitor compares them against imem_* as they appear.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  kind;
  logic [2:0]  alu_op;
  logic [3:0]  rd;
  logic [7:0]  imm;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_acc = 0;
  int c0;
  logic [55:0] exp_q[$];

  instr_encoder_loader #(.N(16), .ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .kind(kind), .alu_op(alu_op),
    .rd(rd), .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
    .fsm_state(fsm_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Monitor: every write the DUT makes must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got %0h@%0h required no write", imem_wdata, imem_addr);
      end else begin
        logic [55:0] e;
        e = exp_q.pop_front();
        check("wr_cycle", cyc, e[55:24]);
        check("wr_addr", {24'h0, imem_addr}, {24'h0, e[23:16]});
        check("wr_word", {16'h0, imem_wdata}, {16'h0, e[15:0]});
      end
    end
  end

  // Driver: starts a burst and returns the cycle count just before the edge that samples start.
  task automatic do_start(input logic [7:0] b, input logic [8:0] l, output int c);
    @(posedge clk); #1;
    base_addr = b;
    len       = l;
    start     = 1'b1;
    @(negedge clk);
    c = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Driver: presents one request and waits (bounded) for it to be accepted.
  // If push is set, the expected write is queued for the monitor.
  task automatic send(input logic [2:0] k, input logic [2:0] a, input logic [3:0] r,
                      input logic [7:0] i, input bit push, input logic [7:0] addr,
                      input logic [15:0] word);
    bit acc;
    kind = k; alu_op = a; rd = r; imm = i;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        last_acc = cyc;
        if (push) exp_q.push_back({32'(cyc + 1), addr, word});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("accept", {31'h0, acc}, 32'h1);
  endtask

  // Waits (bounded) for done, checks its cycle, then checks that it lasted one cycle.
  task automatic wait_done(input int exp_cyc);
    bit found;
    int got;
    found = 1'b0;
    got = -1;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        got = cyc;
      end
    end
    check("done_seen", {31'h0, found}, 32'h1);
    check("done_cycle", got, exp_cyc);
    @(negedge clk);
    check("done_one_cycle", {31'h0, done}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; in_valid = 1'b0;
    kind = '0; alu_op = '0; rd = '0; imm = '0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_we", {31'h0, imem_we}, 32'h0);
    check("rst_addr", {24'h0, imem_addr}, 32'h0);
    check("rst_wdata", {16'h0, imem_wdata}, 32'h0);
    check("rst_busy_done_err", {29'h0, busy, done, err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic burst: MOVI, ALU, LOAD issued back to back
    do_start(8'h10, 9'd3, c0);
    check("busy_after_start", {31'h0, busy}, 32'h1);
    send(3'd0, 3'd0, 4'd4, 8'h2A, 1'b1, 8'h10, 16'h042A);
    check("b2b_first_acc", last_acc, c0 + 1);
    send(3'd1, 3'd3, 4'd1, 8'h05, 1'b1, 8'h11, 16'h3105);
    check("b2b_second_acc", last_acc, c0 + 2);
    send(3'd6, 3'd0, 4'd6, 8'h80, 1'b1, 8'h12, 16'hD680);
    check("b2b_third_acc", last_acc, c0 + 3);
    wait_done(last_acc + 2);
    check("basic_err", {31'h0, err}, 32'h0);

    // Illegal requests: only the final MOVI is written
    do_start(8'h20, 9'd3, c0);
    send(3'd1, 3'd0, 4'd5, 8'h12, 1'b0, 8'h00, 16'h0000);
    check("err_after_illegal_alu", {31'h0, err}, 32'h1);
    send(3'd7, 3'd2, 4'd5, 8'h34, 1'b0, 8'h00, 16'h0000);
    send(3'd0, 3'd0, 4'd2, 8'h01, 1'b1, 8'h20, 16'h0201);
    wait_done(last_acc + 2);
    check("illegal_err_sticky", {31'h0, err}, 32'h1);

    // Jump and store kinds. The new start also clears err.
    do_start(8'h40, 9'd4, c0);
    check("err_cleared_on_start", {31'h0, err}, 32'h0);
    send(3'd2, 3'd0, 4'd0, 8'hFF, 1'b1, 8'h40, 16'h80FF);
    send(3'd3, 3'd0, 4'd0, 8'hFF, 1'b1, 8'h41, 16'h90FF);
    send(3'd4, 3'd0, 4'd0, 8'hFF, 1'b1, 8'h42, 16'hA0FF);
    send(3'd5, 3'd0, 4'd0, 8'hFF, 1'b1, 8'h43, 16'hC0FF);
    wait_done(last_acc + 2);
    check("jump_err", {31'h0, err}, 32'h0);

    // Overflow: only 0xFE and 0xFF are written, then the burst is truncated
    do_start(8'hFE, 9'd5, c0);
    send(3'd0, 3'd0, 4'd1, 8'h11, 1'b1, 8'hFE, 16'h0111);
    send(3'd0, 3'd0, 4'd2, 8'h22, 1'b1, 8'hFF, 16'h0222);
    kind = 3'd0; alu_op = 3'd0; rd = 4'd3; imm = 8'h33;
    in_valid = 1'b1;
    @(negedge clk);
    check("ovf_in_ready_low", {31'h0, in_ready}, 32'h0);
    wait_done(last_acc + 3);
    in_valid = 1'b0;
    check("ovf_err", {31'h0, err}, 32'h1);

    // Backpressure: idle gaps while in_ready is high must not produce writes
    do_start(8'h50, 9'd2, c0);
    check("bp_err_cleared", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    send(3'd0, 3'd0, 4'd7, 8'h01, 1'b1, 8'h50, 16'h0701);
    @(negedge clk);
    check("bp_ready_while_idle", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    send(3'd1, 3'd7, 4'd8, 8'h02, 1'b1, 8'h51, 16'h7802);
    wait_done(last_acc + 2);

    // len=0: done one cycle after start, with no write
    do_start(8'h00, 9'd0, c0);
    wait_done(c0 + 1);

    // Reset while a write is pending
    do_start(8'h60, 9'd3, c0);
    send(3'd0, 3'd0, 4'd4, 8'h55, 1'b0, 8'h00, 16'h0000);
    check("pending_we", {31'h0, imem_we}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_we", {31'h0, imem_we}, 32'h0);
    check("mid_rst_ready", {31'h0, in_ready}, 32'h0);
    check("mid_rst_addr", {24'h0, imem_addr}, 32'h0);
    check("mid_rst_wdata", {16'h0, imem_wdata}, 32'h0);
    check("mid_rst_flags", {29'h0, busy, done, err}, 32'h0);
    check("mid_rst_state", {30'h0, fsm_state}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_start(8'h70, 9'd1, c0);
    send(3'd0, 3'd0, 4'd3, 8'h07, 1'b1, 8'h70, 16'h0307);
    wait_done(last_acc + 2);

    @(negedge clk);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
